// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler
//   Round-robin scheduler that shares an internal 16:1 single-bit mux between
//   16 requesters. A granted requester keeps the mux for up to BURST_LEN
//   accepted beats. The grant is released early if that requester withdraws
//   its request. On release the scheduler re-arbitrates on the same clock
//   edge, so consecutive grants follow each other with no idle cycle.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[15:0]  per-requester request
//   in[15:0]   per-requester data bit
//   out_ready  downstream consumer accepts the current beat
//   out        selected data bit (in[sel] while out_valid, else 0)
//   out_valid  beat available (req[sel] while a grant is active)
//   sel[3:0]   mux select = granted requester index
//   gnt[15:0]  one-hot grant, zero when idle
//   busy       a grant is active
module mux16_rr_scheduler #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] in,
    input  logic        out_ready,
    output logic        out,
    output logic        out_valid,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        busy
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         sel_reg, sel_next;
    logic [3:0]         ptr_reg, ptr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [15:0]        mux_taps;
    logic               mux_bit;
    logic [3:0]         arb_base;
    logic [31:0]        req_dbl;
    logic [15:0]        req_rot;
    logic [3:0]         arb_off;
    logic [3:0]         arb_win;
    logic               arb_any;
    logic               req_sel;
    logic               accept;
    logic               last_beat;
    logic               release_now;

    // 16:1 mux as an AND-OR tree, one tap per requester.
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
        assign mux_taps[gi] = in[gi] & (sel_reg == 4'(gi));
        assign gnt[gi]      = busy & (sel_reg == 4'(gi));
    end
    assign mux_bit = |mux_taps;

    assign busy      = (state_reg == SERVE);
    assign sel       = sel_reg;
    assign req_sel   = req[sel_reg];
    assign out_valid = busy & req_sel;
    assign out       = mux_bit & out_valid;

    assign accept      = out_valid & out_ready;
    assign last_beat   = (cnt_reg == CNT_W'(BURST_LEN - 1));
    assign release_now = busy & (~req_sel | (accept & last_beat));

    // In SERVE, arbitration only matters on release, where the new pointer is
    // sel+1; using it directly lets one arbiter serve both states. The 4-bit
    // add wraps 15 -> 0 naturally.
    assign arb_base = (state_reg == SERVE) ? (sel_reg + 4'd1) : ptr_reg;
    assign req_dbl  = {req, req};
    assign req_rot  = req_dbl[arb_base +: 16];
    assign arb_any  = |req;
    assign arb_win  = arb_base + arb_off;

    // Lowest set bit of the rotated request vector = distance from arb_base.
    always_comb begin
        arb_off = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                arb_off = 4'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    state_next = SERVE;
                    sel_next   = arb_win;
                    cnt_next   = '0;
                end
            end
            SERVE: begin
                if (release_now) begin
                    ptr_next = sel_reg + 4'd1;
                    cnt_next = '0;
                    if (arb_any) begin
                        sel_next = arb_win;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (accept) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sel_reg   <= 4'd0;
            ptr_reg   <= 4'd0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
module tb_mux16_rr_scheduler;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] in;
    logic        out_ready;
    logic        out;
    logic        out_valid;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: who holds the mux, where the priority pointer is,
    // and how many beats the holder has had accepted.
    int m_busy;
    int m_sel;
    int m_ptr;
    int m_cnt;

    mux16_rr_scheduler #(.BURST_LEN(BL), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in        (in),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .sel       (sel),
        .gnt       (gnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // First requester at or after position p, walking upward with wrap.
    function automatic int first_from(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int  w;
        bit  acc;
        if (m_busy == 0) begin
            w = first_from(req, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_cnt = 0;
            end
        end else begin
            acc = req[m_sel] && out_ready;
            if (!req[m_sel] || (acc && m_cnt == BL - 1)) begin
                m_ptr = (m_sel + 1) % 16;
                m_cnt = 0;
                w = first_from(req, m_ptr);
                if (w >= 0) m_sel = w;
                else        m_busy = 0;
            end else if (acc) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [15:0] e_gnt;
        logic        e_vld;
        e_gnt = (m_busy != 0) ? (16'h1 << m_sel) : 16'h0;
        e_vld = (m_busy != 0) && req[m_sel];
        chk("gnt",       gnt,              e_gnt);
        chk("sel",       {12'h0, sel},     16'(m_sel));
        chk("busy",      {15'h0, busy},    16'(m_busy != 0));
        chk("out_valid", {15'h0, out_valid}, {15'h0, e_vld});
        chk("out",       {15'h0, out},     {15'h0, e_vld & in[m_sel]});
    endtask

    // Drive inputs, check the cycle's outputs, then advance one clock.
    task automatic step(input logic [15:0] r, input logic [15:0] d, input logic rdy);
        req = r; in = d; out_ready = rdy;
        #1;
        check_outputs();
        $display("t=%0t req=%h in=%h rdy=%0b -> sel=%0d gnt=%h busy=%0b vld=%0b out=%0b",
                 $time, req, in, out_ready, sel, gnt, busy, out_valid, out);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] rdy_pat;
        rst_n = 1'b1; req = '0; in = '0; out_ready = 1'b0;
        model_reset();
        #2;
        do_reset();

        // 1: single requester 5, back-to-back regrant
        step(16'h0020, 16'h0020, 1'b1);
        chk("t1_sel5", {12'h0, sel}, 16'd5);
        for (int i = 0; i < 12; i++) step(16'h0020, 16'($urandom), 1'b1);
        chk("t1_busy", {15'h0, busy}, 16'h1);

        // 2: all requesting, full rotation plus wrap
        for (int i = 0; i < 70; i++) step(16'hFFFF, 16'($urandom), 1'b1);

        // 3: pointer wrap after requester 15
        do_reset();
        step(16'h8000, 16'($urandom), 1'b1);
        chk("t3_sel15", {12'h0, sel}, 16'd15);
        for (int i = 0; i < BL; i++) step(16'hC008, 16'($urandom), 1'b1);
        chk("t3_sel3", {12'h0, sel}, 16'd3);
        for (int i = 0; i < BL; i++) step(16'h4008, 16'($urandom), 1'b1);
        chk("t3_sel14", {12'h0, sel}, 16'd14);

        // 4: handshake stall, ready pattern 1,0,0,1,1,0,1
        do_reset();
        step(16'h0004, 16'h0000, 1'b1);
        rdy_pat = 16'b1011001;
        for (int i = 0; i < 7; i++) begin
            step(16'h0006, (i % 2 == 0) ? 16'h0004 : 16'h0000, rdy_pat[i]);
            if (i == 5) chk("t4_hold", {12'h0, sel}, 16'd2);
        end
        chk("t4_rel", {12'h0, sel}, 16'd1);

        // 5: withdrawal after two beats
        do_reset();
        step(16'h0280, 16'($urandom), 1'b1);
        chk("t5_sel7", {12'h0, sel}, 16'd7);
        step(16'h0280, 16'($urandom), 1'b1);
        step(16'h0280, 16'($urandom), 1'b1);
        step(16'h0200, 16'($urandom), 1'b1);
        chk("t5_sel9", {12'h0, sel}, 16'd9);

        // 6: asynchronous reset in the middle of a burst
        do_reset();
        step(16'h0400, 16'hFFFF, 1'b1);
        step(16'h0400, 16'hFFFF, 1'b1);
        req = 16'h0400; in = 16'hFFFF; out_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_gnt",  gnt, 16'h0);
        chk("t6_vld",  {15'h0, out_valid}, 16'h0);
        chk("t6_out",  {15'h0, out}, 16'h0);
        chk("t6_busy", {15'h0, busy}, 16'h0);
        chk("t6_sel",  {12'h0, sel}, 16'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        step(16'h0402, 16'($urandom), 1'b1);
        chk("t6_sel1", {12'h0, sel}, 16'd1);

        // Random traffic: sparse requests, mostly-ready consumer
        for (int i = 0; i < 400; i++) begin
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) r = m_busy != 0 ? (r | (16'h1 << m_sel)) : r;
            step(r, 16'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
